// File: rtl/mdio_pkg.sv
// Shared MDIO Clause-22 frame constants and FSM state encoding.
package mdio_pkg;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam int         FRAME_BITS = 32;

  localparam logic [4:0] IDX_HDR_END = 5'd13;
  localparam logic [4:0] IDX_TA_END  = 5'd15;
  localparam logic [4:0] IDX_LAST    = 5'd31;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_WR_TA   = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_RD_TA   = 3'd4;
  localparam logic [2:0] S_RD_DATA = 3'd5;
  localparam logic [2:0] S_SKIP    = 3'd6;

endpackage

// File: rtl/mdio_edge_sync.sv
// Registers MDC/MDIO_OUT/MDIO_OE once and flags MDC rising edges (2 clk after the pin edge).
module mdio_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic mdc_i,
  input  logic mdio_i,
  input  logic oe_i,
  output logic rise_o,
  output logic mdio_o,
  output logic oe_o
);

  logic mdc_q, mdc_qq, mdio_q, oe_q;

  // MDC history resets high so an idle-high MDC does not fake a rise at release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdc_q  <= 1'b1;
      mdc_qq <= 1'b1;
      mdio_q <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      mdc_q  <= mdc_i;
      mdc_qq <= mdc_q;
      mdio_q <= mdio_i;
      oe_q   <= oe_i;
    end
  end

  assign rise_o = mdc_q & ~mdc_qq;
  assign mdio_o = mdio_q;
  assign oe_o   = oe_q;

endmodule

// File: rtl/mdio_peripheral.sv
// Clause-22 MDIO responder: decodes frames for PHY_ADDR, emits register-bus strobes, serializes reads.
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR   = 5'h03,
  parameter int         FRAME_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_STB,
  input  logic [15:0] REG_RD_DATA
);
  import mdio_pkg::*;

  localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS - 1);

  logic rise, mdio_q, oe_q;

  mdio_edge_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .mdc_i  (MDC),
    .mdio_i (MDIO_OUT),
    .oe_i   (MDIO_OE),
    .rise_o (rise),
    .mdio_o (mdio_q),
    .oe_o   (oe_q)
  );

  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        cap_q, cap_d;
  logic        mdio_in_q, mdio_in_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_stb_q, wr_stb_d;
  logic        rd_stb_q, rd_stb_d;
  logic [13:0] hdr;

  // Header as it will look once the bit on this rise is shifted in.
  assign hdr = {shreg_q[12:0], mdio_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    regad_d   = regad_q;
    rd_data_d = rd_data_q;
    mdio_in_d = mdio_in_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    cap_d     = rd_stb_q;
    if (cap_q) rd_data_d = REG_RD_DATA;

    if (rise) begin
      shreg_d = {shreg_q[14:0], mdio_q};
      cnt_d   = cnt_q + 5'd1;
      case (state_q)
        S_IDLE: begin
          if (oe_q) state_d = S_HEADER;
          else      cnt_d   = 5'd0;
        end
        S_HEADER: begin
          if (!oe_q) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
          end else if (cnt_q == IDX_HDR_END) begin
            regad_d = hdr[4:0];
            if (hdr[13:12] != ST_CODE || hdr[9:5] != PHY_ADDR) begin
              state_d = S_SKIP;
            end else if (hdr[11:10] == OP_WRITE) begin
              state_d = S_WR_TA;
            end else if (hdr[11:10] == OP_READ) begin
              state_d  = S_RD_TA;
              addr_d   = hdr[4:0];
              rd_stb_d = 1'b1;
            end else begin
              state_d = S_SKIP;
            end
          end
        end
        S_WR_TA: begin
          if (!oe_q) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
          end else if (cnt_q == IDX_TA_END) begin
            state_d = S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (!oe_q) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
          end else if (cnt_q == LAST_IDX) begin
            addr_d    = regad_q;
            wr_data_d = shreg_d;
            wr_stb_d  = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = 5'd0;
          end
        end
        S_RD_TA: begin
          if (cnt_q == IDX_TA_END) begin
            mdio_in_d = rd_data_q[15];
            state_d   = S_RD_DATA;
          end else begin
            mdio_in_d = 1'b0;
          end
        end
        S_RD_DATA: begin
          if (cnt_q == LAST_IDX) begin
            mdio_in_d = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = 5'd0;
          end else begin
            // Indices 16..30 map to data bits 14..0 for the following slot.
            mdio_in_d = rd_data_q[4'd14 - cnt_q[3:0]];
          end
        end
        S_SKIP: begin
          if (cnt_q == LAST_IDX) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      shreg_q   <= 16'd0;
      regad_q   <= 5'd0;
      rd_data_q <= 16'd0;
      cap_q     <= 1'b0;
      mdio_in_q <= 1'b1;
      addr_q    <= 5'd0;
      wr_data_q <= 16'd0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      regad_q   <= regad_d;
      rd_data_q <= rd_data_d;
      cap_q     <= cap_d;
      mdio_in_q <= mdio_in_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
    end
  end

  assign MDIO_IN = mdio_in_q;
  assign ADDR    = addr_q;
  assign WR_DATA = wr_data_q;
  assign WR_STB  = wr_stb_q;
  assign RD_STB  = rd_stb_q;

endmodule

// File: doc/mdio_peripheral.md
# mdio_peripheral

Management-side MDIO peripheral (PHY-side responder) sitting directly downstream of the MDIO controller. It consumes the controller's MDC, MDIO_OUT and MDIO_OE, and decodes Clause-22 frames addressed to its PHY address. Decoded writes go out as register-bus strobes. For reads it fetches register data and serializes it back on MDIO_IN.

## Interface
- PHY_ADDR, 5'h03: PHY address this peripheral answers to.
- FRAME_BITS, 32: management frame length.
- clk  in  1  system clock, shared with the MDIO controller.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- MDC  in  1  management clock from the controller; high and low phases each ≥ 2 clk.
- MDIO_OUT  in  1  serial data from the controller.
- MDIO_OE  in  1  controller drive enable; 1 means MDIO_OUT is valid.
- MDIO_IN  out  1  serial data to the controller; idles at 1 (pull-up emulation).
- ADDR  out  5  register address from the frame; holds until the next accepted frame.
- WR_DATA  out  16  write payload; holds until the next write.
- WR_STB  out  1  one-clk write strobe.
- RD_STB  out  1  one-clk read request.
- REG_RD_DATA  in  16  register contents; sampled 1 clk after RD_STB.

## Operation
- Input conditioning:
  - MDC, MDIO_OUT and MDIO_OE are each registered once.
  - A second MDC register provides the edge reference.
  - rise = mdc_q & ~mdc_qq.
  - All bit sampling uses the registered mdio_q and oe_q on a rise cycle.
- Frame layout, MSB first, bit index 0..31:
  - ST[0:1] = 01.
  - OP[2:3]: 01 = write, 10 = read.
  - PHYAD[4:8], REGAD[9:13].
  - TA[14:15].
  - DATA[16:31].
- Bit counter: 5 bits, increments on every rise while not IDLE. Index 31 completes the frame and returns to IDLE.
- FSM states:
  - IDLE: on the first rise with oe_q=1, shift bit 0 in and go to HEADER with index 1.
  - HEADER: shift bits 1..13. On the rise sampling bit 13:
    - ST≠01, OP not 01/10, or PHYAD≠PHY_ADDR → SKIP.
    - OP=01 → WR_TA.
    - OP=10 → RD_TA. ADDR is loaded and RD_STB is pulsed the next clk.
  - WR_TA: bits 14..15 ignored → WR_DATA.
  - WR_DATA: shift bits 16..31. After the rise sampling bit 31, ADDR and WR_DATA are loaded and WR_STB pulses for 1 clk → IDLE.
  - RD_TA and RD_DATA, drive sequence. Each new MDIO_IN value is set 1 clk after the rise that sampled the preceding index:
    - bit 14: MDIO_IN = 1.
    - bit 15: MDIO_IN = 0.
    - bits 16..31: REG_RD_DATA[15] down to [0].
    - After the rise at index 31: MDIO_IN = 1 → IDLE.
  - SKIP: count rises to index 31 and do nothing → IDLE. MDIO_IN stays 1.
- Abort: oe_q=0 on any rise in HEADER, WR_TA or WR_DATA → IDLE immediately. No strobe is issued and ADDR/WR_DATA are unchanged. oe_q is ignored during RD_TA, RD_DATA and SKIP.
- A rise arriving in the same clk as an outgoing strobe is handled normally; strobes never delay sampling.

## Timing
- Reset values: MDIO_IN=1, WR_STB=0, RD_STB=0, ADDR=0, WR_DATA=0. FSM=IDLE, counter=0.
- Reset asserted mid-frame forces these values asynchronously. The next frame starts from IDLE.
- Input-to-decision latency: 2 clk from the MDC edge to the rise pulse.
- WR_STB: 1 clk after the rise pulse for bit 31.
- RD_STB: 1 clk after the rise for bit 13. REG_RD_DATA is captured 1 clk later, well before the bit-16 drive.
- The controller samples MDIO_IN at each rise; every MDIO_IN value stays stable for a full MDC period.

## Structure
- Package mdio_pkg holds:
  - ST_CODE=2'b01, OP_WRITE=2'b01, OP_READ=2'b10, FRAME_BITS=32.
  - Bit-index constants 13/15/31.
  - The state encoding: IDLE, HEADER, WR_TA, WR_DATA, RD_TA, RD_DATA, SKIP.
- Sub-module mdio_edge_sync: input registers plus the MDC rise detector. Outputs rise, mdio_q and oe_q.

## Test plan
- Write: PHY_ADDR=3, controller sends 32'h5196F5B5. Expect one WR_STB with ADDR=5'h05 and WR_DATA=16'hF5B5. MDIO_IN stays 1 throughout.
- Read: controller sends header 32'h6194xxxx, OE drops after bit 13, REG_RD_DATA=16'hA5C3. Expect one RD_STB with ADDR=5'h05. MDIO_IN shows 1, 0, then 1010_0101_1100_0011. Controller RD_DATA=16'hA5C3 with DATA_RDY.
- PHY mismatch: 32'h52161234 (PHYAD=4). Expect no strobes and MDIO_IN=1. A following 32'h5196F5B5 is accepted normally.
- Bad ST: 32'h9196F5B5. Expect SKIP, no WR_STB, return to IDLE after 32 rises.
- Abort: OE forced low after bit 20 of a write. Expect no WR_STB and WR_DATA unchanged. The next write completes.
- Reset mid-read: reset=0 at bit 20. Expect MDIO_IN=1, RD_STB=0, ADDR=0 immediately. A fresh read after release returns correct data.
